// File: rtl/axi_frame_slave.sv
// AXI4 slave (single ID, INCR only) that splits bursts into per-beat controller frames
// and buffers read returns in a credit-protected R FIFO.
module axi_frame_slave #(
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
    parameter int RFIFO_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mc_en,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [AXI_ADDR_WIDTH-1:0]  awaddr,
    input  logic [7:0]                 awlen,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic [AXI_DATA_WIDTH-1:0]  wdata,
    input  logic                       wlast,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [1:0]                 bresp,
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [AXI_ADDR_WIDTH-1:0]  araddr,
    input  logic [7:0]                 arlen,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [AXI_DATA_WIDTH-1:0]  rdata,
    output logic                       rlast,
    output logic [1:0]                 rresp,
    output logic [AXI_FRAME_WIDTH-1:0] axi_frame_data,
    output logic                       axi_frame_valid,
    input  logic                       axi_frame_ready,
    input  logic [AXI_DATA_WIDTH-1:0]  axi_array_rdata,
    input  logic                       array_rvalid,
    output logic [2:0]                 dbg_state
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // a source never lowers valid or changes payload while waiting for ready.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        WR_RESP  = 3'd2,
        RD       = 3'd3,
        RD_DRAIN = 3'd4
    } state_t;

    localparam int FW = AXI_FRAME_WIDTH;
    localparam int PW = $clog2(RFIFO_DEPTH);
    localparam int CW = $clog2(RFIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(RFIFO_DEPTH);

    state_t state, state_nxt;

    logic [AXI_ADDR_WIDTH-1:0] base;
    logic [7:0]                len, cnt, ret_cnt;
    logic                      err, done, prio_wr;
    logic [CW-1:0]             fifo_count, outstanding;
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [AXI_DATA_WIDTH:0]   fifo_mem [RFIFO_DEPTH];

    logic                      slot_free, frame_fire, rd_fire, pend_rd, has_credit;
    logic                      grant_wr, grant_rd, aw_hs, ar_hs, w_hs, rd_issue, push, pop;
    logic [CW:0]               used;
    logic [AXI_ADDR_WIDTH-1:0] beat_addr;
    logic                      beat_first, beat_last;

    assign slot_free  = !axi_frame_valid || axi_frame_ready;
    assign frame_fire = axi_frame_valid && axi_frame_ready;
    assign rd_fire    = frame_fire && !axi_frame_data[FW-1];
    assign beat_addr  = base + AXI_ADDR_WIDTH'(cnt);
    assign beat_first = (cnt == 8'd0);
    assign beat_last  = (cnt == len);

    // A loaded-but-unaccepted read frame already owns a FIFO slot, so it is charged here too.
    assign pend_rd    = axi_frame_valid && !axi_frame_data[FW-1];
    assign used       = {1'b0, fifo_count} + {1'b0, outstanding} + {{CW{1'b0}}, pend_rd};
    assign has_credit = (used < DEPTH_C);

    assign grant_wr = awvalid && (!arvalid || prio_wr);
    assign grant_rd = arvalid && (!awvalid || !prio_wr);

    assign push   = array_rvalid;
    assign rvalid = (fifo_count != '0);
    assign pop    = rvalid && rready;
    assign {rdata, rlast} = fifo_mem[rd_ptr];
    assign rresp  = 2'b00;

    assign aw_hs     = awvalid && awready;
    assign ar_hs     = arvalid && arready;
    assign w_hs      = wvalid && wready;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;
        rd_issue  = 1'b0;
        case (state)
            IDLE: begin
                awready = mc_en && grant_wr;
                arready = mc_en && grant_rd;
                if (awready)      state_nxt = WR;
                else if (arready) state_nxt = RD;
            end
            WR: begin
                wready = slot_free && !done;
                if (frame_fire && axi_frame_data[FW-3]) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                bvalid = 1'b1;
                bresp  = err ? 2'b10 : 2'b00;
                if (bready) state_nxt = IDLE;
            end
            RD: begin
                rd_issue = slot_free && has_credit;
                if (rd_issue && beat_last) state_nxt = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (pop && rlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base            <= '0;
            len             <= '0;
            cnt             <= '0;
            err             <= 1'b0;
            done            <= 1'b0;
            prio_wr         <= 1'b1;
            axi_frame_data  <= '0;
            axi_frame_valid <= 1'b0;
            outstanding     <= '0;
            ret_cnt         <= '0;
            fifo_count      <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
        end else begin
            if (aw_hs || ar_hs) begin
                base    <= aw_hs ? awaddr : araddr;
                len     <= aw_hs ? awlen : arlen;
                cnt     <= '0;
                err     <= 1'b0;
                done    <= 1'b0;
                ret_cnt <= '0;
                prio_wr <= ar_hs;
            end
            // The burst counter, not wlast, decides where the burst ends; wlast only flags errors.
            if (w_hs) begin
                cnt <= cnt + 8'd1;
                if (wlast != beat_last) err <= 1'b1;
                if (beat_last) done <= 1'b1;
            end
            if (rd_issue) cnt <= cnt + 8'd1;

            if (w_hs) begin
                axi_frame_data  <= {1'b1, beat_first, beat_last, beat_addr, wdata};
                axi_frame_valid <= 1'b1;
            end else if (rd_issue) begin
                axi_frame_data  <= {1'b0, beat_first, beat_last, beat_addr, {AXI_DATA_WIDTH{1'b0}}};
                axi_frame_valid <= 1'b1;
            end else if (frame_fire) begin
                axi_frame_valid <= 1'b0;
            end

            case ({rd_fire, push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (push) begin
                ret_cnt <= ret_cnt + 8'd1;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {axi_array_rdata, ret_cnt == len};
    end

endmodule

// File: tb/tb_axi_frame_slave.sv
// Directed bench for axi_frame_slave: frame and read-data scoreboards plus a controller
// model that returns each read beat three cycles after its frame is accepted.
module tb_axi_frame_slave;
    localparam int AW    = 20;
    localparam int DW    = 64;
    localparam int FW    = AW + DW + 3;
    localparam int DEPTH = 4;
    localparam logic [2:0] ST_IDLE = 3'd0;

    logic          clk = 1'b0;
    logic          rst_n, mc_en;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [DW-1:0] wdata, rdata, axi_array_rdata;
    logic [1:0]    bresp, rresp;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [FW-1:0] axi_frame_data;
    logic          axi_frame_valid, axi_frame_ready, array_rvalid;
    logic [2:0]    dbg_state;

    logic [FW-1:0] frame_exp_q[$];
    logic [DW:0]   rd_exp_q[$];
    int            ret_due_q[$];
    int            checks = 0;
    int            errors = 0;
    int            rd_fired, rd_popped, outst, fifo_model, ncyc, ret_idx;
    logic [7:0]    cur_len;
    logic          hold_pend;
    logic [FW-1:0] held;

    always #5 clk = ~clk;

    axi_frame_slave #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_FRAME_WIDTH(FW), .RFIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mc_en(mc_en),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp),
        .axi_frame_data(axi_frame_data), .axi_frame_valid(axi_frame_valid),
        .axi_frame_ready(axi_frame_ready), .axi_array_rdata(axi_array_rdata),
        .array_rvalid(array_rvalid), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic wr, input logic first, input logic last,
                                               input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {wr, first, last, a, d};
    endfunction

    // Samples on the falling edge; drives array_rvalid for the following rising edge.
    task automatic monitor();
        logic [FW-1:0] fexp;
        logic [DW:0]   rexp;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                frame_exp_q.delete();
                rd_exp_q.delete();
                ret_due_q.delete();
                rd_fired = 0; rd_popped = 0; outst = 0; fifo_model = 0; ret_idx = 0;
                hold_pend = 1'b0;
                array_rvalid = 1'b0;
            end else begin
                if (hold_pend) check("frame_hold", {axi_frame_valid, axi_frame_data}, {1'b1, held});
                hold_pend = axi_frame_valid && !axi_frame_ready;
                held = axi_frame_data;
                if (array_rvalid) begin
                    check("ret_fifo_not_full", fifo_model < DEPTH, 1);
                    check("ret_outstanding", outst > 0, 1);
                    fifo_model++;
                    outst--;
                end
                if (rvalid && rready) begin
                    check("r_q_nonempty", rd_exp_q.size() != 0, 1);
                    if (rd_exp_q.size() != 0) begin
                        rexp = rd_exp_q.pop_front();
                        check("rdata", rdata, rexp[DW:1]);
                        check("rlast", rlast, rexp[0]);
                    end
                    rd_popped++;
                    fifo_model--;
                end
                if (axi_frame_valid && axi_frame_ready) begin
                    check("frame_q_nonempty", frame_exp_q.size() != 0, 1);
                    if (frame_exp_q.size() != 0) begin
                        fexp = frame_exp_q.pop_front();
                        check("frame", axi_frame_data, fexp);
                    end
                    if (!axi_frame_data[FW-1]) begin
                        rd_fired++;
                        outst++;
                        ret_due_q.push_back(ncyc + 3);
                        check("rd_in_flight", (outst + fifo_model) <= DEPTH, 1);
                    end
                end
                array_rvalid = 1'b0;
                if (ret_due_q.size() != 0 && ret_due_q[0] == ncyc) begin
                    void'(ret_due_q.pop_front());
                    d = {$urandom, $urandom};
                    array_rvalid = 1'b1;
                    axi_array_rdata = d;
                    rd_exp_q.push_back({d, ret_idx == int'(cur_len)});
                    ret_idx = (ret_idx == int'(cur_len)) ? 0 : ret_idx + 1;
                end
            end
        end
    endtask

    task automatic send_aw(input logic [AW-1:0] a, input logic [7:0] l);
        int n;
        awaddr = a; awlen = l; awvalid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (awready) break;
        end
        check("aw_accept", n < 50, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] l);
        int n;
        cur_len = l;
        for (int i = 0; i <= int'(l); i++)
            frame_exp_q.push_back(mk_frame(1'b0, i == 0, i == int'(l), a + AW'(i), '0));
        araddr = a; arlen = l; arvalid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (arready) break;
        end
        check("ar_accept", n < 50, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic last, input logic [AW-1:0] a,
                          input logic first, input logic flast);
        int n;
        frame_exp_q.push_back(mk_frame(1'b1, first, flast, a, d));
        wdata = d; wlast = last; wvalid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wready) break;
        end
        check("w_accept", n < 50, 1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b(input logic [1:0] exp);
        int n;
        bready = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bvalid) break;
        end
        check("b_valid", n < 100, 1);
        check("bresp", bresp, exp);
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (dbg_state == ST_IDLE && frame_exp_q.size() == 0 && rd_exp_q.size() == 0) break;
        end
        check(tag, n < 300, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] d [4];
        logic          is_w;
        int            n, p0, f0;
        rst_n = 1'b0; mc_en = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        awaddr = '0; awlen = '0; araddr = '0; arlen = '0; wdata = '0; wlast = 1'b0;
        axi_frame_ready = 1'b0; array_rvalid = 1'b0; axi_array_rdata = '0;
        cur_len = '0; hold_pend = 1'b0; ncyc = 0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_valid", axi_frame_valid, 0);
        check("rst_frame_data", axi_frame_data, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_wready", wready, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        axi_frame_ready = 1'b1;
        rready = 1'b1;

        // Single-beat write; AW held off while mc_en is low.
        awaddr = 20'h00010; awlen = 8'd0; awvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("aw_gated_mc_en", awready, 0);
        end
        @(posedge clk); #1;
        mc_en = 1'b1;
        send_aw(20'h00010, 8'd0);
        send_w(64'hA5A5_0000_0000_5A5A, 1'b1, 20'h00010, 1'b1, 1'b1);
        @(negedge clk);
        check("t1_frame_latency", axi_frame_valid, 1);
        @(posedge clk); #1;
        wait_b(2'b00);

        // 4-beat write wrapping the address space, frame_ready stalled on beat 2.
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        send_aw(20'hFFFFE, 8'd3);
        send_w(d[0], 1'b0, 20'hFFFFE, 1'b1, 1'b0);
        send_w(d[1], 1'b0, 20'hFFFFF, 1'b0, 1'b0);
        axi_frame_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t2_stall_valid", axi_frame_valid, 1);
            check("t2_stall_data", axi_frame_data, mk_frame(1'b1, 1'b0, 1'b0, 20'hFFFFF, d[1]));
            check("t2_stall_wready", wready, 0);
        end
        @(posedge clk); #1;
        axi_frame_ready = 1'b1;
        send_w(d[2], 1'b0, 20'h00000, 1'b0, 1'b0);
        send_w(d[3], 1'b1, 20'h00001, 1'b0, 1'b1);
        wait_b(2'b00);

        // Early wlast: counter length still governs, response is SLVERR; mc_en drops mid-burst.
        send_aw(20'h00040, 8'd3);
        mc_en = 1'b0;
        for (int i = 0; i < 4; i++)
            send_w({$urandom, $urandom}, i == 2, 20'h00040 + AW'(i), i == 0, i == 3);
        wait_b(2'b10);
        awaddr = 20'h00080; awlen = 8'd0; awvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_no_aw_mc_en_low", awready, 0);
        end
        check("t3_state_idle", dbg_state, ST_IDLE);
        @(posedge clk); #1;
        awvalid = 1'b0;
        mc_en = 1'b1;

        // 8-beat read with rready low: credit caps frames in flight at the FIFO depth.
        rready = 1'b0;
        f0 = rd_fired;
        p0 = rd_popped;
        send_ar(20'h00100, 8'd7);
        repeat (40) @(negedge clk);
        check("t4_frames_before_pop", (rd_fired - f0) <= DEPTH, 1);
        check("t4_rvalid_waiting", rvalid, 1);
        check("t4_no_pop_yet", rd_popped - p0, 0);
        @(posedge clk); #1;
        rready = 1'b1;
        wait_idle("t4_drain_done");
        check("t4_beats_popped", rd_popped - p0, 8);

        // Both AW and AR valid in IDLE for three bursts each: grant alternates from write.
        cur_len = 8'd0;
        begin
            int aw_left = 3;
            int ar_left = 3;
            for (int b = 0; b < 6; b++) begin
                awaddr = 20'h00300 + AW'(b); awlen = 8'd0; awvalid = (aw_left > 0);
                araddr = 20'h00400 + AW'(b); arlen = 8'd0; arvalid = (ar_left > 0);
                for (n = 0; n < 50; n++) begin
                    @(negedge clk);
                    if (awready || arready) break;
                end
                check("t5_grant_seen", n < 50, 1);
                is_w = awready;
                check("t5_grant_order", is_w, (b % 2) == 0);
                if (!is_w) frame_exp_q.push_back(mk_frame(1'b0, 1'b1, 1'b1, 20'h00400 + AW'(b), '0));
                @(posedge clk); #1;
                awvalid = 1'b0;
                arvalid = 1'b0;
                if (is_w) begin
                    aw_left--;
                    send_w({$urandom, $urandom}, 1'b1, 20'h00300 + AW'(b), 1'b1, 1'b1);
                    wait_b(2'b00);
                end else begin
                    ar_left--;
                    wait_idle("t5_read_done");
                end
            end
        end

        // Asynchronous reset during beat 2 of a 4-beat read, then a fresh read from IDLE.
        f0 = rd_fired;
        send_ar(20'h00500, 8'd3);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rd_fired - f0 >= 2) break;
        end
        check("t6_reached_beat2", n < 100, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rvalid", rvalid, 0);
        check("t6_rst_frame_valid", axi_frame_valid, 0);
        check("t6_rst_state", dbg_state, ST_IDLE);
        check("t6_rst_frame_data", axi_frame_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p0 = rd_popped;
        send_ar(20'h00600, 8'd1);
        wait_idle("t6_read_after_reset");
        check("t6_beats_popped", rd_popped - p0, 2);

        check("end_frame_q_empty", frame_exp_q.size(), 0);
        check("end_r_q_empty", rd_exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
